// File: rtl/serial_in_parallel_out_word_capture.sv
// MSB-first serial-to-parallel word capture with bit counting, a valid/ack
// handshake towards the consumer, and a sticky overrun flag.
module serial_in_parallel_out_word_capture #(
    parameter int SIZE  = 4,
    parameter int DELAY = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift_in,
    input  logic                    en,
    input  logic                    sync,
    input  logic                    data_ack,
    output logic [SIZE-1:0]         data_out,
    output logic                    data_valid,
    output logic                    overrun,
    output logic                    busy,
    output logic [$clog2(SIZE)-1:0] bit_cnt
);

    localparam int CNT_W   = $clog2(SIZE);
    // The oldest shifted bit is never observed before capture, so only
    // SIZE-1 history bits are kept; the final bit joins them at capture.
    localparam int SHIFT_W = SIZE - 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    if (SIZE < 2) begin : g_bad_size
        $error("serial_in_parallel_out_word_capture: SIZE must be at least 2");
    end
    // Outputs are driven with zero delay; DELAY is kept only for interface
    // compatibility with the rest of the library.
    if (DELAY < 0) begin : g_bad_delay
        $error("serial_in_parallel_out_word_capture: DELAY must be non-negative");
    end

    typedef enum logic {
        IDLE,
        SHIFTING
    } state_t;

    logic [SHIFT_W-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SIZE-1:0]    data_reg, data_next;
    logic               valid_reg, valid_next;
    logic               overrun_reg, overrun_next;
    logic               capture;
    logic               overrun_set;
    state_t             state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            cnt_reg     <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state        = (cnt_reg == '0) ? IDLE : SHIFTING;
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        capture      = 1'b0;
        overrun_set  = 1'b0;

        if (sync) begin
            // Realign: the bit strobed alongside sync starts the new word.
            shift_next = en ? SHIFT_W'(shift_in) : '0;
            cnt_next   = en ? CNT_W'(1) : '0;
        end else if (en) begin
            shift_next = SHIFT_W'({shift_reg, shift_in});
            case (state)
                IDLE: cnt_next = CNT_W'(1);
                SHIFTING: begin
                    if (cnt_reg == LAST_BIT) begin
                        capture  = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: cnt_next = '0;
            endcase
        end

        if (capture) begin
            data_next   = {shift_reg, shift_in};
            valid_next  = 1'b1;
            overrun_set = valid_reg && !data_ack;
        end else if (data_ack) begin
            valid_next = 1'b0;
        end

        if (overrun_set) begin
            overrun_next = 1'b1;
        end else if (data_ack) begin
            overrun_next = 1'b0;
        end
    end

    assign data_out   = data_reg;
    assign data_valid = valid_reg;
    assign overrun    = overrun_reg;
    assign bit_cnt    = cnt_reg;
    assign busy       = (cnt_reg != '0);

endmodule

// File: tb/tb_serial_in_parallel_out_word_capture.sv
// Table-driven bench for the SIZE=4 word capture block; captured words are
// also checked through a scoreboard fed from the driven bit stream.
module tb_serial_in_parallel_out_word_capture;

    localparam int SIZE = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            shift_in = 1'b0;
    logic            en = 1'b0;
    logic            sync = 1'b0;
    logic            data_ack = 1'b0;
    logic [SIZE-1:0] data_out;
    logic            data_valid;
    logic            overrun;
    logic            busy;
    logic [1:0]      bit_cnt;

    int checks = 0;
    int errors = 0;

    serial_in_parallel_out_word_capture #(.SIZE(SIZE), .DELAY(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_in   (shift_in),
        .en         (en),
        .sync       (sync),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .busy       (busy),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       sin;
        logic       sync;
        logic       ack;
        logic [3:0] out;
        logic       valid;
        logic       ovr;
        logic [1:0] cnt;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];
    logic [3:0] acc = '0;
    int         nbits = 0;

    task automatic add(input logic e, input logic s, input logic sy, input logic a,
                       input logic [3:0] o, input logic v, input logic ov, input logic [1:0] c);
        vec_t t;
        t = '{en: e, sin: s, sync: sy, ack: a, out: o, valid: v, ovr: ov, cnt: c};
        vecs.push_back(t);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (data_out !== 4'h0 || data_valid !== 1'b0 || overrun !== 1'b0 ||
            busy !== 1'b0 || bit_cnt !== 2'd0) begin
            errors++;
            $display("FAIL %s: got out=%h valid=%b ovr=%b busy=%b cnt=%0d, need all zero",
                     name, data_out, data_valid, overrun, busy, bit_cnt);
        end else begin
            $display("%s: all outputs zero", name);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [3:0] want;
        logic [8:0] got_t, exp_t;
        bit         pushed;
        @(negedge clk);
        en = v.en; shift_in = v.sin; sync = v.sync; data_ack = v.ack;
        pushed = 1'b0;
        if (v.en) begin
            if (v.sync) begin
                acc = {3'b000, v.sin};
                nbits = 1;
            end else begin
                acc = {acc[2:0], v.sin};
                nbits++;
                if (nbits == SIZE) begin
                    exp_q.push_back(acc);
                    nbits = 0;
                    pushed = 1'b1;
                end
            end
        end else if (v.sync) begin
            nbits = 0;
        end
        @(posedge clk);
        #1;
        checks++;
        got_t = {data_out, data_valid, overrun, bit_cnt, busy};
        exp_t = {v.out, v.valid, v.ovr, v.cnt, (v.cnt != 2'd0)};
        if (got_t !== exp_t) begin
            errors++;
            $display("FAIL vec%0d: got out=%h valid=%b ovr=%b cnt=%0d busy=%b, need out=%h valid=%b ovr=%b cnt=%0d busy=%b",
                     idx, data_out, data_valid, overrun, bit_cnt, busy,
                     v.out, v.valid, v.ovr, v.cnt, (v.cnt != 2'd0));
        end else begin
            $display("vec%0d en=%b in=%b sync=%b ack=%b -> out=%h valid=%b ovr=%b cnt=%0d",
                     idx, v.en, v.sin, v.sync, v.ack, data_out, data_valid, overrun, bit_cnt);
        end
        if (pushed) begin
            want = exp_q.pop_front();
            checks++;
            if (data_out !== want || data_valid !== 1'b1) begin
                errors++;
                $display("FAIL word%0d: got out=%h valid=%b, need out=%h valid=1",
                         idx, data_out, data_valid, want);
            end else begin
                $display("word at vec%0d: captured %h", idx, data_out);
            end
        end
    endtask

    initial begin
        // Single word 1011 then ack
        add(1,1,0,0, 4'h0,0,0,1); add(1,0,0,0, 4'h0,0,0,2);
        add(1,1,0,0, 4'h0,0,0,3); add(1,1,0,0, 4'hB,1,0,0);
        add(0,0,0,1, 4'hB,0,0,0);
        // Gapped strobe 0110, shift_in toggling during gaps
        add(1,0,0,0, 4'hB,0,0,1); add(0,1,0,0, 4'hB,0,0,1); add(0,1,0,0, 4'hB,0,0,1);
        add(1,1,0,0, 4'hB,0,0,2); add(0,0,0,0, 4'hB,0,0,2); add(0,1,0,0, 4'hB,0,0,2);
        add(1,1,0,0, 4'hB,0,0,3); add(0,1,0,0, 4'hB,0,0,3); add(0,1,0,0, 4'hB,0,0,3);
        add(1,0,0,0, 4'h6,1,0,0); add(0,0,0,1, 4'h6,0,0,0);
        // Back-to-back 0xA, 0x5 without ack -> overrun
        add(1,1,0,0, 4'h6,0,0,1); add(1,0,0,0, 4'h6,0,0,2);
        add(1,1,0,0, 4'h6,0,0,3); add(1,0,0,0, 4'hA,1,0,0);
        add(1,0,0,0, 4'hA,1,0,1); add(1,1,0,0, 4'hA,1,0,2);
        add(1,0,0,0, 4'hA,1,0,3); add(1,1,0,0, 4'h5,1,1,0);
        add(0,0,0,1, 4'h5,0,0,0);
        // 0x3 then 0xC with ack on the 0xC capture cycle
        add(1,0,0,0, 4'h5,0,0,1); add(1,0,0,0, 4'h5,0,0,2);
        add(1,1,0,0, 4'h5,0,0,3); add(1,1,0,0, 4'h3,1,0,0);
        add(1,1,0,0, 4'h3,1,0,1); add(1,1,0,0, 4'h3,1,0,2);
        add(1,0,0,0, 4'h3,1,0,3); add(1,0,0,1, 4'hC,1,0,0);
        add(0,0,0,1, 4'hC,0,0,0); add(0,0,0,1, 4'hC,0,0,0);
        // sync mid-word with en: word restarts, captures 1001
        add(1,1,0,0, 4'hC,0,0,1); add(1,1,0,0, 4'hC,0,0,2);
        add(1,1,1,0, 4'hC,0,0,1); add(1,0,0,0, 4'hC,0,0,2);
        add(1,0,0,0, 4'hC,0,0,3); add(1,1,0,0, 4'h9,1,0,0);
        // sync+en on the capture cycle: no capture; then sync alone
        add(1,0,0,0, 4'h9,1,0,1); add(1,1,0,0, 4'h9,1,0,2);
        add(1,1,0,0, 4'h9,1,0,3); add(1,0,1,0, 4'h9,1,0,1);
        add(0,1,1,0, 4'h9,1,0,0);
        // Two bits in, ready for the asynchronous reset
        add(1,1,0,0, 4'h9,1,0,1); add(1,0,0,0, 4'h9,1,0,2);

        @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Asynchronous reset between edges at bit_cnt=2, data_valid=1
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_with_en");
        en = 1'b0;
        nbits = 0;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d words left, need 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
